// File: rtl/keypad_pkg.sv
// Shared keypad constants and the event encoding used by the keypad event path.
package keypad_pkg;

  localparam int KEY_COUNT   = 16;
  localparam int EVT_W       = 5;
  localparam int RELEASE_BIT = 4;
  localparam int CODE_W      = 4;
  localparam int PEND_W      = 2 * KEY_COUNT;
  localparam int PEND_IDX_W  = 5;

  typedef logic [EVT_W-1:0] key_event_t;

  // Event word: release flag above the 4-bit key code (code = key index - 1).
  function automatic key_event_t make_event(input logic rel, input logic [CODE_W-1:0] code);
    key_event_t ev;
    ev                   = {EVT_W{1'b0}};
    ev[CODE_W-1:0]       = code;
    ev[RELEASE_BIT]      = rel;
    return ev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Head word; forced to zero when empty so stale storage never leaks out.
  always_comb begin
    pop_data = {WIDTH{1'b0}};
    if (empty) begin
      pop_data = {WIDTH{1'b0}};
    end else begin
      pop_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns the keypad level vector into queued press/release events with
// round-robin arbitration of pending edges and a valid/ready output port.
module key_event_queue
  import keypad_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter bit REPORT_RELEASE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [16:1]             keys,
  input  logic                    en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_event,
  output logic                    overflow,
  input  logic                    clr_ovf,
  output logic [$clog2(DEPTH):0]  count
);

  logic [KEY_COUNT-1:0]    keys_q_r;
  logic [KEY_COUNT-1:0]    prev_r;
  logic                    armed_r;
  logic [PEND_W-1:0]       pending_r;
  logic [PEND_IDX_W-1:0]   rr_ptr_r;
  logic                    overflow_r;

  logic [PEND_W-1:0]       edges_s;
  logic [PEND_W-1:0]       pending_nxt_s;
  logic [PEND_W-1:0]       grant_oh_s;
  logic [2*PEND_W-1:0]     dbl_s;
  logic [PEND_W-1:0]       rot_s;
  logic [PEND_IDX_W-1:0]   hit_s;
  logic [PEND_IDX_W-1:0]   grant_idx_s;
  logic                    grant_s;
  logic                    ovf_set_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    pop_s;
  key_event_t              push_event_s;

  // Input sample and previous-level tracking run every cycle, reset included.
  always_ff @(posedge clk) begin
    keys_q_r <= keys;
    prev_r   <= keys_q_r;
  end

  // Edge detection; suppressed until armed so keys held through reset stay silent.
  always_comb begin
    edges_s = {PEND_W{1'b0}};
    if (armed_r && en) begin
      edges_s[KEY_COUNT-1:0] = keys_q_r & ~prev_r;
      if (REPORT_RELEASE) begin
        edges_s[PEND_W-1:KEY_COUNT] = ~keys_q_r & prev_r;
      end else begin
        edges_s[PEND_W-1:KEY_COUNT] = {KEY_COUNT{1'b0}};
      end
    end else begin
      edges_s = {PEND_W{1'b0}};
    end
  end

  // Round-robin pick: rotate pending so rr_ptr lands at bit 0, take the lowest set bit.
  always_comb begin
    dbl_s = {pending_r, pending_r} >> rr_ptr_r;
    rot_s = dbl_s[PEND_W-1:0];
    hit_s = {PEND_IDX_W{1'b0}};
    for (int i = PEND_W - 1; i >= 0; i--) begin
      hit_s = rot_s[i] ? PEND_IDX_W'(i) : hit_s;
    end
    grant_s     = (|pending_r) && !fifo_full_s;
    grant_idx_s = rr_ptr_r + hit_s;
    grant_oh_s  = grant_s ? (32'd1 << grant_idx_s) : {PEND_W{1'b0}};
  end

  // A new edge on a bit that is still pending (and not leaving now) merges and is lost.
  always_comb begin
    pending_nxt_s = (pending_r & ~grant_oh_s) | edges_s;
    ovf_set_s     = |(edges_s & pending_r & ~grant_oh_s);
  end

  // Arbiter, pending and overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r    <= 1'b0;
      pending_r  <= {PEND_W{1'b0}};
      rr_ptr_r   <= {PEND_IDX_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      armed_r   <= 1'b1;
      pending_r <= pending_nxt_s;
      if (grant_s) begin
        rr_ptr_r <= grant_idx_s + PEND_IDX_W'(1);
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign push_event_s = make_event(grant_idx_s[RELEASE_BIT], grant_idx_s[CODE_W-1:0]);
  assign pop_s        = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_s),
    .push_data (push_event_s),
    .pop       (pop_s),
    .pop_data  (out_event),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (count)
  );

  assign out_valid = ~fifo_empty_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench: a queue-based reference model predicts every event; a monitor
// compares DUT output against it. A second instance checks the press-only variant.
module tb_key_event_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam bit REL   = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic [16:1]   keys;
  logic          en;
  logic          out_ready;
  logic          clr_ovf;
  logic          out_valid;
  logic [4:0]    out_event;
  logic          overflow;
  logic [CW-1:0] count;

  logic          v0;
  logic [4:0]    ev0;
  logic          ovf0;
  logic [CW-1:0] cnt0;

  always #10 clk = ~clk;

  key_event_queue #(.DEPTH(DEPTH), .REPORT_RELEASE(REL)) dut (
    .clk(clk), .rst(rst), .keys(keys), .en(en),
    .out_valid(out_valid), .out_ready(out_ready), .out_event(out_event),
    .overflow(overflow), .clr_ovf(clr_ovf), .count(count)
  );

  key_event_queue #(.DEPTH(DEPTH), .REPORT_RELEASE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .keys(keys), .en(en),
    .out_valid(v0), .out_ready(1'b1), .out_event(ev0),
    .overflow(ovf0), .clr_ovf(clr_ovf), .count(cnt0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_kq = 16'h0;
  logic [15:0] m_prev = 16'h0;
  bit          m_armed = 1'b0;
  bit          m_pend [32];
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [4:0]  exp_q [$];

  always @(posedge clk) begin : model
    bit pop, gv, ovs;
    int g, idx;
    bit e [32];
    if (rst) begin
      m_prev  = m_kq;
      m_kq    = keys;
      m_armed = 1'b0;
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      pop = (m_cnt > 0) && out_ready;
      gv  = 1'b0;
      g   = 0;
      if (m_cnt < DEPTH) begin
        for (int i = 0; i < 32; i++) begin
          idx = (m_ptr + i) % 32;
          if (!gv && m_pend[idx]) begin
            gv = 1'b1;
            g  = idx;
          end
        end
      end
      foreach (e[k]) e[k] = 1'b0;
      if (m_armed && en) begin
        for (int k = 0; k < 16; k++) begin
          if (m_kq[k] && !m_prev[k]) e[k] = 1'b1;
          if (REL && !m_kq[k] && m_prev[k]) e[k+16] = 1'b1;
        end
      end
      if (gv) begin
        m_pend[g] = 1'b0;
        exp_q.push_back(5'(g));
        m_ptr = (g + 1) % 32;
      end
      ovs = 1'b0;
      for (int k = 0; k < 32; k++) begin
        if (e[k]) begin
          if (m_pend[k]) ovs = 1'b1;
          m_pend[k] = 1'b1;
        end
      end
      if (ovs) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_cnt   = m_cnt + int'(gv) - int'(pop);
      m_prev  = m_kq;
      m_kq    = keys;
      m_armed = 1'b1;
    end
  end

  function automatic bit model_idle();
    bit any = 1'b0;
    foreach (m_pend[k]) any |= m_pend[k];
    return !any && (m_cnt == 0) && (m_kq == m_prev) && (m_kq == keys);
  endfunction

  // ---------------- monitor ----------------
  int pops = 0;
  int pops02 = 0;
  int pops16 = 0;
  int rel0 = 0;
  int prs0 = 0;

  always @(negedge clk) begin : monitor
    logic [4:0] exp_ev;
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
      chk("count", 32'(count), 32'(m_cnt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got event %0h expected none at %0t", out_event, $time);
        end else begin
          exp_ev = exp_q.pop_front();
          chk("out_event", 32'(out_event), 32'(exp_ev));
        end
        pops++;
        if (out_event == 5'h02) pops02++;
        if (out_event == 5'h16) pops16++;
      end
      if (v0) begin
        if (ev0[4]) rel0++;
        else prs0++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [16:1] k);
    rst = 1'b1;
    keys = k;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    cyc(1);
    while (n < 500 && !model_idle()) begin
      cyc(1);
      n++;
    end
    cyc(2);
    chk("drain_done", 32'(n < 500), 32'd1);
    chk("drain_count0", 32'(count), 32'd0);
  endtask

  initial begin
    int snap, snap_p0, snap_r0;
    rst = 1'b1; keys = 16'h0001; en = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;

    // Held through reset: key 1 down before and after reset -> no event.
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_event", 32'(out_event), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("held_no_event", 32'(out_valid), 32'd0);
    end

    // Single press then release of key 6.
    do_reset(16'h0000);
    out_ready = 1'b1;
    cyc(2);
    keys = 16'h0020;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("press_valid", 32'(out_valid), 32'd1);
    chk("press_event", 32'(out_event), 32'h05);
    cyc(7);
    keys = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_event", 32'(out_event), 32'h15);
    drain();

    // Simultaneous press, rr_ptr fresh from reset.
    do_reset(16'h0000);
    out_ready = 1'b0;
    cyc(1);
    keys = 16'h8003;
    cyc(6);
    @(negedge clk);
    chk("simul_count", 32'(count), 32'd3);
    chk("simul_head", 32'(out_event), 32'h00);
    cyc(3);
    @(negedge clk);
    chk("simul_head_stable", 32'(out_event), 32'h00);
    cyc(1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("simul_order0", 32'(out_event), 32'h00);
    @(negedge clk);
    chk("simul_order1", 32'(out_event), 32'h01);
    @(negedge clk);
    chk("simul_order2", 32'(out_event), 32'h0F);
    cyc(1);
    keys = 16'h0000;
    drain();

    // Full stall: 12 presses into an 8-deep FIFO.
    do_reset(16'h0000);
    out_ready = 1'b0;
    cyc(1);
    keys = 16'h0FFF;
    cyc(20);
    @(negedge clk);
    chk("stall_count", 32'(count), 32'(DEPTH));
    chk("stall_overflow", 32'(overflow), 32'd0);
    snap = pops;
    cyc(1);
    drain();
    chk("stall_all_out", 32'(pops - snap), 32'd12);
    keys = 16'h0000;
    drain();

    // Merge: key 3 press/release/press while FIFO is full.
    do_reset(16'h0000);
    out_ready = 1'b0;
    cyc(1);
    keys = 16'hFF00;
    cyc(12);
    keys = 16'hFF04;
    cyc(2);
    keys = 16'hFF00;
    cyc(2);
    keys = 16'hFF04;
    cyc(3);
    @(negedge clk);
    chk("merge_overflow", 32'(overflow), 32'd1);
    cyc(1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("clr_overflow", 32'(overflow), 32'd0);
    snap = pops02;
    cyc(1);
    drain();
    chk("merge_single_02", 32'(pops02 - snap), 32'd1);
    keys = 16'h0000;
    drain();

    // en gating on key 7, then release with en high.
    do_reset(16'h0000);
    en = 1'b0;
    out_ready = 1'b1;
    snap_p0 = prs0;
    snap_r0 = rel0;
    cyc(1);
    keys = 16'h0040;
    cyc(6);
    @(negedge clk);
    chk("en0_count", 32'(count), 32'd0);
    chk("en0_rr0_none", 32'(prs0 - snap_p0), 32'd0);
    cyc(1);
    en = 1'b1;
    snap = pops16;
    cyc(3);
    keys = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("en1_rel_valid", 32'(out_valid), 32'd1);
    chk("en1_rel_event", 32'(out_event), 32'h16);
    cyc(5);
    chk("en1_rel_once", 32'(pops16 - snap), 32'd1);
    chk("rr0_no_release_evt", 32'((prs0 - snap_p0) + (rel0 - snap_r0)), 32'd0);

    // Randomized traffic with occasional resets.
    do_reset(16'h0000);
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if ($urandom_range(0, 2) == 0) keys = keys ^ 16'(32'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) keys = 16'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 249) == 0);
    end
    cyc(1);
    rst = 1'b0;
    en = 1'b1;
    keys = 16'h0000;
    drain();

    chk("rr0_never_release", 32'(rel0), 32'd0);
    chk("rr0_saw_press", 32'(prs0 > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sequences the 16-bit level-type key vector from the matrix-keypad scanner into discrete press/release events for the CPU.
- Detects edges on every key and arbitrates the pending events round-robin.
- Buffers events in a small FIFO and hands them to the CPU through a valid/ready port.
- Sits between the keypad converter output and the CPU input/IO register logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPORT_RELEASE, 1, 1 = release events are generated; 0 = press events only.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- keys  in  16 [16:1]  key levels from the keypad converter, 1 = pressed, same clock domain.
- en  in  1  1 = edges are captured; 0 = edges are ignored, previous-state tracking and draining continue.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head event.
- out_event  out  5  {release, code[3:0]}; code = key index - 1.
- overflow  out  1  sticky: an event was lost.
- clr_ovf  in  1  clears overflow.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. On reset, out_valid=0, out_event=0, overflow=0, count=0, pending=0, rr_ptr=0, armed=0.
- Input register: keys_q <= keys every cycle.
- armed register: set 1 on the first cycle after reset. While armed=0, prev <= keys_q and no edges are generated, so keys held through reset produce no event.
- Edge detect, active when armed and en: press = keys_q & ~prev; release = ~keys_q & prev (forced 0 if REPORT_RELEASE=0). prev <= keys_q every cycle.
- Pending vector: 32 bits, index = {release, code}.
  - A detected edge sets its bit.
  - If the bit is already set and not being granted this cycle, the event merges and overflow <= 1.
  - If the bit is set and granted in the same cycle as a new edge, the bit stays 1 and both events survive.
- Arbiter: one grant per cycle.
  - Grant only when pending != 0 and count < DEPTH. There is no push-through when full, even if a pop happens in the same cycle.
  - Search order: rr_ptr, rr_ptr+1, ... mod 32. The first set bit wins.
  - On grant: rr_ptr <= granted index + 1 (mod 32), the pending bit clears, and the event is written at the tail.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
  - out_event is the head entry, driven combinationally from storage. It holds stable while out_valid && !out_ready.
  - Pointers wrap modulo DEPTH.
- Latency:
  - A key change present at rising edge E0 is captured into keys_q.
  - The pending bit sets at E1.
  - The event is pushed at E2.
  - out_valid=1 after E2, assuming an empty FIFO and no competing pending bits.
- clr_ovf: overflow <= 0. If a new overflow occurs in the same cycle, set wins.
- Overflow only originates from merged pending bits. A full FIFO stalls the arbiter and never drops events directly.
- rst mid-operation: all pending, FIFO contents and overflow are discarded. The next cycle re-arms per the armed rule.
- en=0 does not clear pending; the queue continues to drain.

Decomposition:
- Shared package (keypad_pkg) holds:
  - constants KEY_COUNT=16, EVT_W=5, RELEASE_BIT=4;
  - a function that builds an event from {release, code}.
- Natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). It is reusable by the UART and other IO blocks.
- Arbiter and edge detection stay in key_event_queue.

Test Plan:
- Held through reset: keys=16'h0001 during and after rst -> no event; out_valid stays 0 for 20 cycles.
- Single press/release: keys 0->16'h0020 for 10 cycles, then 0, out_ready=1.
  - out_event=5'h05 with out_valid high 3 edges after the change.
  - Then 5'h15.
  - count returns to 0.
- Simultaneous press: keys 0->16'h8003 with out_ready=0.
  - FIFO gets 5'h00, 5'h01, 5'h0F in that order (rr_ptr from 0).
  - count=3; out_event holds 5'h00 stable.
- Full stall: out_ready=0, 12 distinct presses with DEPTH=8 -> count=8, 4 bits stay pending, overflow=0. Raise out_ready -> all 12 emerge in order, none lost.
- Merge/overflow: out_ready=0, fill FIFO; toggle key 3 press, release, press -> overflow=1 and only one 5'h02 is queued. Pulse clr_ovf -> overflow=0.
- en gating and REPORT_RELEASE=0: with en=0, press key 7 -> no event. Release it after en=1 -> no event when REPORT_RELEASE=0; 5'h16 when REPORT_RELEASE=1.
